// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative restoring unsigned divider, one quotient bit per
//               clock, with valid/ready handshakes on operands and results.
// Revision    : 1.0 - initial release
// ============================================================================

module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int c_dw = 2 * WIDTH;
    localparam int c_cw = (c_dw > 1) ? $clog2(c_dw) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_dw - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [c_dw-1:0]     r_dq;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_dvs;
    logic [c_cw-1:0]     r_count;
    logic [c_dw-1:0]     r_quotient;
    logic [WIDTH-1:0]    r_remainder;
    logic                r_dbz;

    logic                w_accept;
    logic                w_zero;
    logic                w_last;
    logic [WIDTH:0]      w_shift;
    logic                w_ge;
    logic [WIDTH-1:0]    w_rem_step;
    logic [c_dw-1:0]     w_dq_step;

    assign w_accept = in_valid && in_ready;
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_count == c_last);

    // One restoring step: the shifted partial remainder is WIDTH+1 bits so a
    // carried-out MSB still compares correctly; the difference always fits
    // in WIDTH bits because it ends up below the divisor.
    assign w_shift    = {r_rem, r_dq[c_dw-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_step = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
    assign w_dq_step  = {r_dq[c_dw-2:0], w_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_zero ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dq        <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend[WIDTH-1:0];
                    r_dbz       <= 1'b1;
                end else begin
                    r_dq    <= dividend;
                    r_rem   <= '0;
                    r_dvs   <= divisor;
                    r_count <= '0;
                end
            end else if (r_state == ST_BUSY) begin
                r_dq    <= w_dq_step;
                r_rem   <= w_rem_step;
                r_count <= r_count + c_cw'(1);
                if (w_last) begin
                    r_quotient  <= w_dq_step;
                    r_remainder <= w_rem_step;
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
